ex_alu_stage: RTL
=================

# ex_alu_stage

Execute-stage ALU with NZCV flag register and EX/MEM output register for the ARM-style datapath. Sits directly downstream of the shifter/sign-extender: it consumes the shifted second operand and the shifter carry-out, combines it with Rn per the data-processing opcode, and evaluates the condition field against the current flags. It registers the result toward memory/writeback. Flags are updated only by executed instructions with S set.

## Interface
- Parameters:
- `WIDTH`, 32, datapath width.
- Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `valid_in`  in  1  instruction present in EX this cycle.
- `stall`  in  1  hold EX/MEM register and flags.
- `flush`  in  1  kill the instruction in EX.
- `opcode`  in  4  data-processing opcode, instruction bits [24:21].
- `s_bit`  in  1  update flags.
- `cond`  in  4  condition field, instruction bits [31:28].
- `rn`  in  WIDTH  first operand.
- `n`  in  WIDTH  shifter operand, the shifter output N.
- `shifter_carry`  in  1  shifter carry-out.
- `rd_in`  in  4  destination register.
- `valid_out`  out  1  registered valid; reset 0.
- `result`  out  WIDTH  registered ALU result; reset 0.
- `rd_out`  out  4  registered destination; reset 0.
- `wb_en`  out  1  registered writeback enable; reset 0.
- `flags`  out  4  NZCV register, bit 3 = N; reset 4'b0000.
- `cond_pass`  out  1  combinational condition result for the current EX instruction.

## Operation
- Opcodes: AND 0, EOR 1, SUB 2, RSB 3, ADD 4, ADC 5, SBC 6, RSC 7, TST 8, TEQ 9, CMP A, CMN B, ORR C, MOV D, BIC E, MVN F.
- Subtraction uses A + ~B + cin:
  - SUB: cin = 1.
  - SBC/RSC: cin = C.
  - C is NOT borrow.
- Arithmetic ops compute on WIDTH+1 bits. C is bit WIDTH of the sum. V = (sign of A == sign of B') && (sign of result != sign of A), where B' is the post-inversion operand.
- Logical ops (AND, EOR, TST, TEQ, ORR, MOV, BIC, MVN): C = `shifter_carry`; V is unchanged.
- N = result[WIDTH-1]. Z = (result == 0).
- Condition codes 0–E follow the standard ARM definitions. Code F is treated as never.
- An instruction is executed when `valid_in && cond_pass && !flush`.
- For an executed instruction:
  - The flag write occurs when `s_bit` is set. TST/TEQ/CMP/CMN always write flags, regardless of `s_bit`.
  - `wb_en` = 1 except for opcodes 8–B.
- A condition-failed instruction still propagates: `valid_out` = 1, `wb_en` = 0, no flag write.

## Timing
- Latency is 1 cycle from EX inputs to the registered outputs.
- `cond_pass` uses the flags register value at the start of the cycle. The flags written by instruction i are visible to instruction i+1 in the next cycle; no bypass is needed.
- Priority at each edge is `rst_n` low > `flush` > `stall` > normal.
- Reset: all outputs and flags are cleared at the next edge. An in-flight instruction is discarded.
- Flush: at the next edge `valid_out` = 0, `wb_en` = 0, and flags are held. Flush overrides a simultaneous stall.
- Stall (without flush): all registered outputs and flags hold. The instruction in EX causes no flag write, because upstream re-presents it.
- When `valid_in` = 0: `valid_out` = 0, `wb_en` = 0, and flags are held.

## Configuration
- `ALU_COND_EXEC_EN` defined: the condition evaluation described above.
- `ALU_COND_EXEC_EN` undefined: `cond` is ignored and `cond_pass` is tied to 1, so every valid instruction executes (AL). The `cond_check` instance is omitted.

## Structure
- Package `alu_pkg` holds:
  - the opcode enum;
  - the condition-code enum;
  - the flag bit indices N=3, Z=2, C=1, V=0;
  - the helper constant for the compare-only opcode range 8–B.
- Sub-module `cond_check` is combinational: inputs `cond[3:0]` and `flags[3:0]`, output `pass`.
- The ALU datapath and the registers live in `ex_alu_stage`.

## Test plan
- Signed-overflow ADD: ADDS, rn=0x7FFFFFFF, n=1 → result 0x80000000, flags N=1 Z=0 C=0 V=1 after 1 cycle.
- Equal compare then conditional execute: CMP rn=5 n=5 → flags Z=1 C=1, `wb_en`=0. Next cycle, MOVNE n=9 → `cond_pass`=0, `valid_out`=1, `wb_en`=0, flags still 0110.
- Borrow chain:
  - SUBS rn=0 n=1 → result 0xFFFFFFFF, C=0.
  - Then SBC rn=0 n=0 → result 0xFFFFFFFF.
- Logical carry: ANDS rn=0xF0 n=0x0F, `shifter_carry`=1, with prior V=1 → result 0, Z=1 C=1 V=1.
- Pipeline control:
  - ADDS held under `stall` for 3 cycles → outputs and flags frozen.
  - `flush` together with `stall` → `valid_out`=0 next cycle, flags unchanged.
- Reset mid-stream: `rst_n` low during a valid ADDS → next edge all outputs 0, flags 0000. Without `ALU_COND_EXEC_EN`, cond=F still executes.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode/condition encodings and NZCV bit positions for the EX-stage ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
    OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
    OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
    OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF
  } opcode_e;

  typedef enum logic [3:0] {
    CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3,
    CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7,
    CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'hA, CC_LT = 4'hB,
    CC_GT = 4'hC, CC_LE = 4'hD, CC_AL = 4'hE, CC_NV = 4'hF
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Compare-only opcodes (TST/TEQ/CMP/CMN) never write back a register.
  localparam logic [3:0] OP_CMP_FIRST = 4'h8;
  localparam logic [3:0] OP_CMP_LAST  = 4'hB;

endpackage

// File: rtl/ex_alu_stage_cond_check.sv
// Combinational ARM condition-field evaluator; code F (NV) never passes.
module cond_check
  import alu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic f_n, f_z, f_c, f_v;

  assign f_n = flags[FLAG_N];
  assign f_z = flags[FLAG_Z];
  assign f_c = flags[FLAG_C];
  assign f_v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond_e'(cond))
      CC_EQ:   pass = f_z;
      CC_NE:   pass = !f_z;
      CC_CS:   pass = f_c;
      CC_CC:   pass = !f_c;
      CC_MI:   pass = f_n;
      CC_PL:   pass = !f_n;
      CC_VS:   pass = f_v;
      CC_VC:   pass = !f_v;
      CC_HI:   pass = f_c && !f_z;
      CC_LS:   pass = !f_c || f_z;
      CC_GE:   pass = (f_n == f_v);
      CC_LT:   pass = (f_n != f_v);
      CC_GT:   pass = !f_z && (f_n == f_v);
      CC_LE:   pass = f_z || (f_n != f_v);
      CC_AL:   pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_alu_stage.sv
// Execute-stage ALU with NZCV register and EX/MEM output register; macro ALU_COND_EXEC_EN enables conditional execution.
// Latency: 1 cycle EX inputs to registered outputs; cond_pass is combinational from current flags.
// Backpressure: stall holds outputs and flags; flush kills the EX instruction and overrides stall.
module ex_alu_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic             stall,
  input  logic             flush,
  input  logic [3:0]       opcode,
  input  logic             s_bit,
  input  logic [3:0]       cond,
  input  logic [WIDTH-1:0] rn,
  input  logic [WIDTH-1:0] n,
  input  logic             shifter_carry,
  input  logic [3:0]       rd_in,
  output logic             valid_out,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       rd_out,
  output logic             wb_en,
  output logic [3:0]       flags,
  output logic             cond_pass
);

  opcode_e          op;
  logic             is_cmp;
  logic             arith;
  logic             cin;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] logic_res;
  logic [WIDTH-1:0] alu_res;
  logic             c_next;
  logic             v_next;
  logic [3:0]       next_flags;
  logic             exec;
  logic             flag_we;

  assign op     = opcode_e'(opcode);
  assign is_cmp = (opcode >= OP_CMP_FIRST) && (opcode <= OP_CMP_LAST);

`ifdef ALU_COND_EXEC_EN
  cond_check u_cond_check (
    .cond  (cond),
    .flags (flags),
    .pass  (cond_pass)
  );
`else
  logic unused_cond;
  assign unused_cond = ^cond;
  assign cond_pass   = 1'b1;
`endif

  // Subtraction is A + ~B + cin so that C comes out as NOT-borrow.
  always_comb begin
    op_a  = rn;
    op_b  = n;
    cin   = 1'b0;
    arith = 1'b1;
    case (op)
      OP_SUB, OP_CMP: begin op_b = ~n; cin = 1'b1; end
      OP_RSB:         begin op_a = n; op_b = ~rn; cin = 1'b1; end
      OP_ADD, OP_CMN: cin = 1'b0;
      OP_ADC:         cin = flags[FLAG_C];
      OP_SBC:         begin op_b = ~n; cin = flags[FLAG_C]; end
      OP_RSC:         begin op_a = n; op_b = ~rn; cin = flags[FLAG_C]; end
      default:        arith = 1'b0;
    endcase
  end

  assign sum = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, cin};

  always_comb begin
    logic_res = '0;
    case (op)
      OP_AND, OP_TST: logic_res = rn & n;
      OP_EOR, OP_TEQ: logic_res = rn ^ n;
      OP_ORR:         logic_res = rn | n;
      OP_MOV:         logic_res = n;
      OP_BIC:         logic_res = rn & ~n;
      OP_MVN:         logic_res = ~n;
      default:        logic_res = '0;
    endcase
  end

  assign alu_res = arith ? sum[WIDTH-1:0] : logic_res;
  assign c_next  = arith ? sum[WIDTH] : shifter_carry;
  assign v_next  = arith ? ((op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]))
                         : flags[FLAG_V];

  always_comb begin
    next_flags         = '0;
    next_flags[FLAG_N] = alu_res[WIDTH-1];
    next_flags[FLAG_Z] = (alu_res == '0);
    next_flags[FLAG_C] = c_next;
    next_flags[FLAG_V] = v_next;
  end

  assign exec    = valid_in && cond_pass && !flush;
  assign flag_we = exec && (s_bit || is_cmp) && !stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      result    <= '0;
      rd_out    <= '0;
      wb_en     <= 1'b0;
      flags     <= 4'b0000;
    end else if (flush) begin
      valid_out <= 1'b0;
      wb_en     <= 1'b0;
    end else if (!stall) begin
      valid_out <= valid_in;
      wb_en     <= exec && !is_cmp;
      if (valid_in) begin
        result <= alu_res;
        rd_out <= rd_in;
      end
      if (flag_we) flags <= next_flags;
    end
  end

endmodule
